// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the ring/Johnson counter step controller.
package counter_ctrl_pkg;

  // Width of the issued-step counter.
  localparam int unsigned CNT_W = 4;

  // Step mode encodings on the Mode input; 2'b11 behaves as manual.
  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_BURST  = 2'b10;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_AUTO_RUN  = 2'b01,
    ST_BURST_RUN = 2'b10
  } state_t;

endpackage

// File: rtl/counter_step_debounce.sv
// Synchronizes and debounces a raw button, emitting a one-cycle pulse on
// each debounced press (0->1). Releases produce nothing.
module counter_step_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      level_q <= level;
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/counter_step_sequencer.sv
// Step controller for the ring/Johnson counter pair: debounced manual steps,
// auto free-run and fixed-length burst stepping, clear and complement control.
module counter_step_sequencer
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AUTO_PERIOD     = 50000000,
  parameter int unsigned BURST_LEN       = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             BTN,
  input  logic             ClearBtn,
  input  logic [1:0]       Mode,
  input  logic             ComplementReq,
  output logic             Step,
  output logic             Clear,
  output logic             Complement,
  output logic [CNT_W-1:0] StepCount,
  output logic             Busy
);

  localparam int unsigned   PW       = $clog2(AUTO_PERIOD);
  localparam logic [PW-1:0] PLAST    = PW'(AUTO_PERIOD - 1);
  localparam logic [CNT_W-1:0] REM_LOAD = CNT_W'(BURST_LEN - 1);

  logic             step_press;
  logic             clr_press;
  logic [1:0]       mode_m, mode_s;
  logic             comp_m, comp_s;
  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             step_d;

  counter_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk   (CLK),
    .rst   (Reset),
    .din   (BTN),
    .press (step_press)
  );

  counter_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk   (CLK),
    .rst   (Reset),
    .din   (ClearBtn),
    .press (clr_press)
  );

  // Two-flop synchronizers for the mode and complement switches.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      mode_m <= '0;
      mode_s <= '0;
      comp_m <= 1'b0;
      comp_s <= 1'b0;
    end else begin
      mode_m <= Mode;
      mode_s <= mode_m;
      comp_m <= ComplementReq;
      comp_s <= comp_m;
    end
  end

  // Next-state, prescaler, burst count and step decision.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    rem_d   = rem_q;
    step_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mode_s == MODE_AUTO) begin
          state_d = ST_AUTO_RUN;
          presc_d = '0;
        end else if (mode_s == MODE_BURST) begin
          if (step_press) begin
            state_d = ST_BURST_RUN;
            step_d  = 1'b1;
            rem_d   = REM_LOAD;
            presc_d = '0;
          end
        end else begin
          step_d = step_press;
        end
      end
      ST_AUTO_RUN: begin
        if (mode_s != MODE_AUTO) begin
          state_d = ST_IDLE;
          presc_d = '0;
        end else if (presc_q == PLAST) begin
          step_d  = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_BURST_RUN: begin
        // Leaving on rem_q==0 keeps Busy high through the last step cycle.
        if (mode_s != MODE_BURST || rem_q == '0) begin
          state_d = ST_IDLE;
        end else if (presc_q == PLAST) begin
          step_d  = 1'b1;
          presc_d = '0;
          rem_d   = rem_q - CNT_W'(1);
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Clear wins over everything, including a coincident step.
    if (clr_press) begin
      state_d = ST_IDLE;
      step_d  = 1'b0;
      rem_d   = '0;
      presc_d = '0;
    end
  end

  // FSM, prescaler and burst count registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      rem_q   <= rem_d;
    end
  end

  // Registered counter controls; complement only changes on step/clear.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      Step       <= 1'b0;
      Clear      <= 1'b0;
      Complement <= 1'b0;
      StepCount  <= '0;
    end else begin
      Step  <= step_d;
      Clear <= clr_press;
      if (step_d || clr_press) Complement <= comp_s;
      if (clr_press)   StepCount <= '0;
      else if (step_d) StepCount <= StepCount + CNT_W'(1);
    end
  end

  assign Busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_counter_step_sequencer.sv
// Directed bench for counter_step_sequencer with DEBOUNCE_CYCLES=4,
// AUTO_PERIOD=5, BURST_LEN=3. Edge numbers are counted from the point
// where each scenario first drives its stimulus.
module tb_counter_step_sequencer;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       BTN = 1'b0;
  logic       ClearBtn = 1'b0;
  logic [1:0] Mode = 2'b00;
  logic       ComplementReq = 1'b0;
  logic       Step, Clear, Complement, Busy;
  logic [3:0] StepCount;

  int checks = 0;
  int errors = 0;

  counter_step_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD    (5),
    .BURST_LEN      (3)
  ) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .BTN          (BTN),
    .ClearBtn     (ClearBtn),
    .Mode         (Mode),
    .ComplementReq(ComplementReq),
    .Step         (Step),
    .Clear        (Clear),
    .Complement   (Complement),
    .StepCount    (StepCount),
    .Busy         (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    BTN = 1'b0;
    ClearBtn = 1'b0;
    Mode = 2'b00;
    ComplementReq = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (Step !== 1'b0) begin errors++; $display("FAIL reset_step: got %0b expected 0", Step); end
    checks++; if (Clear !== 1'b0) begin errors++; $display("FAIL reset_clear: got %0b expected 0", Clear); end
    checks++; if (Complement !== 1'b0) begin errors++; $display("FAIL reset_complement: got %0b expected 0", Complement); end
    checks++; if (StepCount !== 4'd0) begin errors++; $display("FAIL reset_stepcount: got %0d expected 0", StepCount); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", Busy); end
    do_reset();
    tick();
    checks++; if (Busy !== 1'b0 || Step !== 1'b0) begin errors++; $display("FAIL reset_release: busy=%0b step=%0b expected 0/0", Busy, Step); end
  endtask

  task automatic test_manual();
    int n = 0;
    int first = -1;
    do_reset();
    BTN = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 11) BTN = 1'b0;
      tick();
      if (Step === 1'b1) begin
        n++;
        if (first < 0) first = i;
      end
    end
    checks++; if (n != 1) begin errors++; $display("FAIL manual_count: got %0d steps expected 1", n); end
    checks++; if (first != 7) begin errors++; $display("FAIL manual_latency: step at edge %0d expected 7", first); end
    checks++; if (StepCount !== 4'd1) begin errors++; $display("FAIL manual_stepcount: got %0d expected 1", StepCount); end
    n = 0;
    BTN = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      if (i == 4) BTN = 1'b0;
      tick();
      if (Step === 1'b1) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL manual_glitch: got %0d steps expected 0", n); end
    checks++; if (StepCount !== 4'd1) begin errors++; $display("FAIL manual_glitch_count: got %0d expected 1", StepCount); end
  endtask

  task automatic test_auto();
    int n = 0;
    int pos[8];
    do_reset();
    Mode = 2'b01;
    for (int i = 1; i <= 40; i++) begin
      if (i == 28) Mode = 2'b00;
      tick();
      if (Step === 1'b1) begin
        if (n < 8) pos[n] = i;
        n++;
      end
    end
    checks++; if (n != 5) begin errors++; $display("FAIL auto_count: got %0d steps expected 5", n); end
    for (int k = 0; k < 5 && k < n; k++) begin
      checks++;
      if (pos[k] != 8 + 5 * k) begin errors++; $display("FAIL auto_pos%0d: step at edge %0d expected %0d", k, pos[k], 8 + 5 * k); end
    end
    checks++; if (StepCount !== 4'd5) begin errors++; $display("FAIL auto_stepcount: got %0d expected 5", StepCount); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL auto_busy_exit: got %0b expected 0", Busy); end
  endtask

  task automatic test_burst();
    int n = 0;
    int pos[8];
    logic busy17 = 1'b0;
    logic busy18 = 1'b1;
    do_reset();
    Mode = 2'b10;
    tick(); tick(); tick();
    for (int i = 1; i <= 30; i++) begin
      BTN = (i <= 6) || (i >= 11 && i <= 24);
      tick();
      if (Step === 1'b1) begin
        if (n < 8) pos[n] = i;
        n++;
      end
      if (i == 17) busy17 = Busy;
      if (i == 18) busy18 = Busy;
    end
    BTN = 1'b0;
    checks++; if (n != 3) begin errors++; $display("FAIL burst_count: got %0d steps expected 3", n); end
    for (int k = 0; k < 3 && k < n; k++) begin
      checks++;
      if (pos[k] != 7 + 5 * k) begin errors++; $display("FAIL burst_pos%0d: step at edge %0d expected %0d", k, pos[k], 7 + 5 * k); end
    end
    checks++; if (busy17 !== 1'b1) begin errors++; $display("FAIL burst_busy_last: got %0b expected 1", busy17); end
    checks++; if (busy18 !== 1'b0) begin errors++; $display("FAIL burst_busy_drop: got %0b expected 0", busy18); end
    checks++; if (StepCount !== 4'd3) begin errors++; $display("FAIL burst_stepcount: got %0d expected 3", StepCount); end
  endtask

  task automatic test_clear_vs_step();
    int found = 0;
    do_reset();
    Mode = 2'b01;
    for (int i = 0; i < 30 && found == 0; i++) begin
      tick();
      if (Step === 1'b1) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++; $display("FAIL clear_wait_step: no step within 30 cycles, expected one");
    end else begin
      for (int t = 1; t <= 10; t++) begin
        tick();
        if (t == 3) ClearBtn = 1'b1;
        if (t == 5) begin
          checks++; if (Step !== 1'b1 || StepCount !== 4'd2) begin errors++; $display("FAIL clear_prior_step: step=%0b count=%0d expected 1/2", Step, StepCount); end
        end
        if (t == 9) begin
          checks++; if (Clear !== 1'b0) begin errors++; $display("FAIL clear_early: got %0b expected 0", Clear); end
        end
      end
      checks++; if (Clear !== 1'b1) begin errors++; $display("FAIL clear_pulse: got %0b expected 1", Clear); end
      checks++; if (Step !== 1'b0) begin errors++; $display("FAIL clear_suppress_step: got %0b expected 0", Step); end
      checks++; if (StepCount !== 4'd0) begin errors++; $display("FAIL clear_stepcount: got %0d expected 0", StepCount); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL clear_idle: busy=%0b expected 0", Busy); end
      tick();
      checks++; if (Clear !== 1'b0) begin errors++; $display("FAIL clear_one_cycle: got %0b expected 0", Clear); end
    end
    ClearBtn = 1'b0;
    Mode = 2'b00;
  endtask

  task automatic test_complement();
    do_reset();
    ComplementReq = 1'b1;
    repeat (5) tick();
    checks++; if (Complement !== 1'b0) begin errors++; $display("FAIL comp_hold_idle: got %0b expected 0", Complement); end
    BTN = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) begin
        checks++; if (Complement !== 1'b0) begin errors++; $display("FAIL comp_before_step: got %0b expected 0", Complement); end
      end
    end
    checks++; if (Step !== 1'b1 || Complement !== 1'b1) begin errors++; $display("FAIL comp_load1: step=%0b comp=%0b expected 1/1", Step, Complement); end
    BTN = 1'b0;
    ComplementReq = 1'b0;
    repeat (12) tick();
    checks++; if (Complement !== 1'b1) begin errors++; $display("FAIL comp_hold_between: got %0b expected 1", Complement); end
    BTN = 1'b1;
    repeat (7) tick();
    checks++; if (Step !== 1'b1 || Complement !== 1'b0) begin errors++; $display("FAIL comp_load0: step=%0b comp=%0b expected 1/0", Step, Complement); end
    BTN = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    do_reset();
    Mode = 2'b10;
    ComplementReq = 1'b1;
    tick(); tick(); tick();
    BTN = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      if (i == 9) BTN = 1'b0;
      tick();
      if (Step === 1'b1) n++;
    end
    checks++; if (n != 2 || StepCount !== 4'd2) begin errors++; $display("FAIL rst_burst_pre: steps=%0d count=%0d expected 2/2", n, StepCount); end
    Reset = 1'b1;
    #1;
    checks++;
    if (Step !== 1'b0 || Clear !== 1'b0 || Complement !== 1'b0 || StepCount !== 4'd0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_burst_outputs: step=%0b clear=%0b comp=%0b count=%0d busy=%0b expected all 0", Step, Clear, Complement, StepCount, Busy);
    end
    tick(); tick();
    Reset = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (Step === 1'b1) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL rst_burst_no_third: got %0d steps expected 0", n); end
    checks++; if (StepCount !== 4'd0 || Busy !== 1'b0) begin errors++; $display("FAIL rst_burst_after: count=%0d busy=%0b expected 0/0", StepCount, Busy); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto();
    test_burst();
    test_clear_vs_step();
    test_complement();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/counter_step_sequencer.md
# counter_step_sequencer

Step controller for the ring/Johnson counter pair. It debounces the raw push-button and clear inputs and turns them into single-cycle `Step` and `Clear` enables. It can also generate steps itself at a fixed rate, either free-running or as a fixed-length burst. It runs on the board clock and drives the counters' step enable, clear and complement controls, so the counters no longer use the raw button as their clock.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: number of consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz); must be ≥ 2.
- `AUTO_PERIOD`, 50000000: number of cycles between generated steps; must be ≥ 2.
- `BURST_LEN`, 8: number of steps per burst; range 1..15.

Ports:
- `CLK`, in, 1: board clock; all logic is on the rising edge.
- `Reset`, in, 1: asynchronous, active-high.
- `BTN`, in, 1: raw step button, active-high when pressed, asynchronous to `CLK`.
- `ClearBtn`, in, 1: raw clear button, active-high, asynchronous.
- `Mode`, in, 2: step mode. 00 = manual, 01 = auto free-run, 10 = burst, 11 = treated as manual.
- `ComplementReq`, in, 1: requested complement level, from a switch.
- `Step`, out, 1: one-cycle enable to both counters.
- `Clear`, out, 1: one-cycle synchronous clear to both counters.
- `Complement`, out, 1: complement level applied to the counters.
- `StepCount`, out, 4: number of steps issued since the last reset or clear, wrapping mod 16.
- `Busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- Input conditioning:
  - `BTN`, `ClearBtn`, `Mode` and `ComplementReq` each pass through a 2-flop synchronizer.
  - `BTN` and `ClearBtn` are then debounced. A debounced level flips only after the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles; any glitch restarts that count.
  - A press event is the debounced 0→1 transition. Releases generate nothing.
- FSM states: IDLE, AUTO_RUN, BURST_RUN.
  - IDLE → AUTO_RUN when synchronized `Mode`=01. The prescaler is cleared on entry.
  - IDLE → BURST_RUN on a press event while `Mode`=10. The first step is issued in the entry cycle, the remaining count is loaded with `BURST_LEN`−1, and the prescaler is cleared.
  - AUTO_RUN → IDLE when `Mode`≠01. The prescaler is cleared.
  - BURST_RUN → IDLE after the last step, or when `Mode`≠10.
  - Any state → IDLE on a clear event.
- Step sources:
  - Manual (IDLE, `Mode`=00/11): a press event gives `Step`=1 in the following cycle.
  - AUTO_RUN: `Step`=1 when the prescaler equals `AUTO_PERIOD`−1; the prescaler then wraps to 0.
  - BURST_RUN: same prescaler rule, with the remaining count decremented on each step.
  - Press events in AUTO_RUN or BURST_RUN are ignored.
- Clear:
  - A `ClearBtn` press event gives `Clear`=1 for one cycle.
  - `StepCount` returns to 0 and any burst is aborted.
  - `Clear` has priority over `Step`: if both fall in the same cycle, `Step` is suppressed.
- Complement:
  - `Complement` is loaded from the synchronized `ComplementReq` only in cycles where `Step` or `Clear` is 1.
  - The counters therefore never see a complement change between steps.
- `StepCount` increments on every issued `Step` and wraps from 15 to 0.

## Timing
- Reset values: `Step`=0, `Clear`=0, `Complement`=0, `StepCount`=0, `Busy`=0. FSM in IDLE, debounced levels 0, prescaler 0, synchronizers 0.
- Manual step latency, from the first cycle the raw `BTN` is high and stable: 2 (synchronizer) + `DEBOUNCE_CYCLES` + 1 cycles to `Step`.
- Auto mode: the first step comes `AUTO_PERIOD` cycles after entering AUTO_RUN, then every `AUTO_PERIOD` cycles exactly.
- Burst mode:
  - Steps at cycles t, t+`AUTO_PERIOD`, and so on, `BURST_LEN` steps in total.
  - `Busy` drops in the cycle after the last step.
  - With `BURST_LEN`=1 the FSM leaves BURST_RUN immediately.
- `Step` and `Clear` are never high for two consecutive cycles from the same event.
- Reset asserted mid-burst or mid-debounce: all state returns to reset values immediately. A button still held at release of `Reset` produces a press event after normal debounce.

## Structure
- Shared package `counter_ctrl_pkg`:
  - FSM state encoding.
  - `Mode` encodings: MODE_MANUAL, MODE_AUTO, MODE_BURST.
  - Counter width constant (4).
- Sub-module `counter_step_debounce`: 2-flop synchronizer, stability counter and rising-edge detect, producing a one-cycle press pulse. It is instantiated twice, for `BTN` and `ClearBtn`.
- Top level: FSM, prescaler, burst counter, `StepCount` and complement register.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `AUTO_PERIOD`=5, `BURST_LEN`=3.
- Manual: `BTN` held high 10 cycles → exactly one `Step`, arriving 7 cycles after `BTN` rises; `StepCount`=1. A 3-cycle `BTN` glitch → no `Step`.
- Auto: `Mode`=01 for 27 cycles → `Step` every 5 cycles, 5 steps total, `StepCount`=5. Switch to `Mode`=00 → `Busy`=0 and no further steps.
- Burst: `Mode`=10 and one press → 3 steps spaced 5 cycles apart, then `Busy`=0. A second press mid-burst is ignored, leaving `StepCount`=3.
- Clear vs step: `ClearBtn` press aligned with an auto step → `Clear`=1, `Step`=0, `StepCount`=0, FSM returns to IDLE.
- Complement: `ComplementReq` toggled between steps → `Complement` changes only in the next `Step` cycle.
- Reset mid-burst: `Reset` pulsed after the 2nd step → all outputs 0, no 3rd step.
